// File: rtl/tdc_pkg.sv
// Shared widths, word layout and FIFO occupancy states for the TDC result path.
// Output width grows by TDC_TSW when TDC_RESULT_TSTAMP_EN is defined.
package tdc_pkg;

  localparam int TDC_DW  = 28;
  localparam int TDC_AW  = 4;
  localparam int TDC_TSW = 16;

`ifdef TDC_RESULT_TSTAMP_EN
  localparam int TDC_OW = TDC_TSW + TDC_AW + TDC_DW;
`else
  localparam int TDC_OW = TDC_AW + TDC_DW;
`endif

  typedef struct packed {
    logic [TDC_AW-1:0] addr;
    logic [TDC_DW-1:0] data;
  } tdc_word_t;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fifo_state_e;

endpackage

// File: rtl/tdc_result_buffer_if.sv
// Valid/ready result stream between the TDC result buffer and the host/ALU side.
// The stream width follows tdc_pkg::TDC_OW, which depends on TDC_RESULT_TSTAMP_EN.
interface tdc_result_buffer_if #(
  parameter int OW = tdc_pkg::TDC_OW
);

  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/tdc_sync_fifo.sv
// Generic DEPTH x W first-word-fall-through FIFO with synchronous flush.
// Occupancy state (EMPTY/PARTIAL/FULL) is kept registered so valid/full come straight from flops.
module tdc_sync_fifo
  import tdc_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_state_e   state_q, state_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_i) wrPtr_d = wrPtr_q + 1'b1;
      if (pop_i)  rdPtr_d = rdPtr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wrPtr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = PARTIAL;
    if (count_d == '0)            state_d = EMPTY;
    else if (count_d == CW'(DEPTH)) state_d = FULL;
  end

  // Head word is gated to zero when empty so the stream never shows stale storage.
  always_comb begin
    valid_o = (state_q != EMPTY);
    full_o  = (state_q == FULL);
    rdata_o = valid_o ? mem_q[rdPtr_q] : '0;
    count_o = count_q;
  end

endmodule

// File: rtl/tdc_result_buffer.sv
// Captures TDC result words on the read controller's completion pulse and streams them out.
// Define TDC_RESULT_TSTAMP_EN to prepend a free-running cycle timestamp to every word.
module tdc_result_buffer
  import tdc_pkg::*;
#(
  parameter int DW    = TDC_DW,
  parameter int AW    = TDC_AW,
  parameter int DEPTH = 16,
  parameter int TSW   = TDC_TSW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trig_in,
  input  logic [DW-1:0]          data_in,
  input  logic [AW-1:0]          addr_in,
  input  logic                   flush,
  input  logic                   ovf_clr,
  tdc_result_buffer_if.master    m_if,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

`ifdef TDC_RESULT_TSTAMP_EN
  localparam int OW = TSW + AW + DW;
`else
  localparam int OW = AW + DW;
`endif

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TSW < 1) begin : gBadParam
    $error("tdc_result_buffer: DEPTH must be a power of two >= 2 and TSW >= 1");
  end

  logic [AW+DW-1:0] shadow_q;
  logic [OW-1:0]    wordIn;
  logic             fifoValid, fifoFull;
  logic             push, pop, drop;
  logic             overflow_q, overflow_d;
  logic [7:0]       dropCnt_q, dropCnt_d;

  // The controller has already released the bus when trig_in fires, so push last cycle's bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow_q <= '0;
    else       shadow_q <= {addr_in, data_in};
  end

`ifdef TDC_RESULT_TSTAMP_EN
  logic [TSW-1:0] tstamp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tstamp_q <= '0;
    else       tstamp_q <= tstamp_q + 1'b1;
  end

  assign wordIn = {tstamp_q, shadow_q};
`else
  assign wordIn = shadow_q;
`endif

  // A trigger coincident with flush is neither stored nor counted as lost.
  assign pop  = fifoValid & m_if.m_ready;
  assign push = trig_in & ~flush & (~fifoFull | pop);
  assign drop = trig_in & ~flush & fifoFull & ~pop;

  tdc_sync_fifo #(
    .W     (OW),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (wordIn),
    .rdata_o (m_if.m_data),
    .valid_o (fifoValid),
    .full_o  (fifoFull),
    .count_o (count)
  );

  // A drop in the same cycle as ovf_clr wins, leaving the flag set and a count of one.
  always_comb begin
    overflow_d = overflow_q;
    dropCnt_d  = dropCnt_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
      dropCnt_d  = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (dropCnt_d != 8'hFF) dropCnt_d = dropCnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
    end else begin
      overflow_q <= overflow_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  assign m_if.m_valid = fifoValid;
  assign full         = fifoFull;
  assign overflow     = overflow_q;
  assign drop_cnt     = dropCnt_q;

endmodule
